// File: rtl/conv_tx_arbiter.sv
// Arbitrates two word requesters onto one 32-to-8 serialiser. Sticky ownership is capped
// by a burst limit, and the converter is driven with enable, width code and byte index.
module conv_tx_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic        REQ0_VALID,
    input  logic [31:0] REQ0_DATA,
    input  logic [1:0]  REQ0_PCLK,
    input  logic        REQ1_VALID,
    input  logic [31:0] REQ1_DATA,
    input  logic [1:0]  REQ1_PCLK,
    output logic        REQ0_READY,
    output logic        REQ1_READY,
    output logic [31:0] CONV_IN_DATA,
    output logic [1:0]  CONV_PCLK,
    output logic        CONV_ENB,
    output logic [1:0]  CONV_BIT,
    output logic        GRANT,
    output logic        BUSY,
    output logic        ERR
);
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state, state_next;
    logic [3:0]  burst_cnt;
    logic [1:0]  last_bit;
    logic        arb_point;
    logic        owner_valid, other_valid;
    logic        win_any, win_sel, accept;
    logic [31:0] win_data;
    logic [1:0]  win_pclk;

    always_comb begin
        case (CONV_PCLK)
            2'b00:   last_bit = 2'd3;
            2'b01:   last_bit = 2'd1;
            default: last_bit = 2'd0;
        endcase
    end

    // State register together with the registered converter-side outputs
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state        <= IDLE;
            CONV_IN_DATA <= 32'd0;
            CONV_PCLK    <= 2'd0;
            CONV_ENB     <= 1'b0;
            CONV_BIT     <= 2'd0;
            GRANT        <= 1'b0;
            BUSY         <= 1'b0;
            ERR          <= 1'b0;
            burst_cnt    <= 4'd0;
        end else begin
            state    <= state_next;
            CONV_ENB <= (state_next == SEND);
            BUSY     <= (state_next == SEND);
            ERR      <= accept && (win_pclk == 2'b11);
            if (accept) begin
                CONV_IN_DATA <= win_data;
                CONV_PCLK    <= win_pclk;
                GRANT        <= win_sel;
                CONV_BIT     <= 2'd0;
                if (win_sel != GRANT)
                    burst_cnt <= 4'd1;
                else if (burst_cnt != 4'hF)
                    burst_cnt <= burst_cnt + 4'd1;
            end else if (state == SEND && !arb_point) begin
                CONV_BIT <= CONV_BIT + 2'd1;
            end else begin
                CONV_BIT  <= 2'd0;
                burst_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        win_pclk   = win_sel ? REQ1_PCLK : REQ0_PCLK;
        win_data   = win_sel ? REQ1_DATA : REQ0_DATA;
        state_next = state;
        if (accept)
            state_next = (win_pclk == 2'b11) ? IDLE : SEND;
        else if (state == SEND && arb_point)
            state_next = IDLE;
    end

    // Reserved codes are accepted in IDLE so they still consume a burst slot
    always_comb begin
        arb_point   = (state == IDLE) || (CONV_BIT == last_bit);
        owner_valid = GRANT ? REQ1_VALID : REQ0_VALID;
        other_valid = GRANT ? REQ0_VALID : REQ1_VALID;
        win_any     = 1'b0;
        win_sel     = GRANT;
        if (owner_valid && (burst_cnt < BURST_LIM)) begin
            win_any = 1'b1;
        end else if (other_valid) begin
            win_any = 1'b1;
            win_sel = ~GRANT;
        end else if (owner_valid) begin
            win_any = 1'b1;
        end
        accept     = RESET_L && arb_point && win_any;
        REQ0_READY = accept && !win_sel;
        REQ1_READY = accept && win_sel;
    end
endmodule

// File: tb/tb_conv_tx_arbiter.sv
// Directed bench for conv_tx_arbiter: handshake, width codes, burst arbitration and async reset.
module tb_conv_tx_arbiter;
    logic        CLK;
    logic        RESET_L;
    logic        REQ0_VALID, REQ1_VALID;
    logic [31:0] REQ0_DATA, REQ1_DATA;
    logic [1:0]  REQ0_PCLK, REQ1_PCLK;
    logic        REQ0_READY, REQ1_READY;
    logic [31:0] CONV_IN_DATA;
    logic [1:0]  CONV_PCLK;
    logic        CONV_ENB;
    logic [1:0]  CONV_BIT;
    logic        GRANT, BUSY, ERR;

    int n_cmp = 0;
    int n_bad = 0;

    conv_tx_arbiter #(.MAX_BURST(4)) dut (
        .CLK(CLK), .RESET_L(RESET_L),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_PCLK(REQ0_PCLK),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_PCLK(REQ1_PCLK),
        .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
        .CONV_IN_DATA(CONV_IN_DATA), .CONV_PCLK(CONV_PCLK), .CONV_ENB(CONV_ENB),
        .CONV_BIT(CONV_BIT), .GRANT(GRANT), .BUSY(BUSY), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_L = 1'b0;
        REQ0_VALID = 1'b1; REQ0_DATA = 32'hA1B2C3D4; REQ0_PCLK = 2'b00;
        REQ1_VALID = 1'b0; REQ1_DATA = 32'h0;        REQ1_PCLK = 2'b00;
        #3;
        check("rst_enb", CONV_ENB, 0);
        check("rst_busy", BUSY, 0);
        check("rst_bit", CONV_BIT, 0);
        check("rst_grant", GRANT, 0);
        check("rst_err", ERR, 0);
        check("rst_data", CONV_IN_DATA, 0);
        check("rst_ready0", REQ0_READY, 0);
        tick(); tick();

        // single 4-byte word from requester 0
        RESET_L = 1'b1;
        #1;
        check("t1_ready0", REQ0_READY, 1);
        check("t1_ready1", REQ1_READY, 0);
        tick();
        REQ0_VALID = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            check("t1_enb", CONV_ENB, 1);
            check("t1_busy", BUSY, 1);
            check("t1_bit", CONV_BIT, b);
            check("t1_data", CONV_IN_DATA, 32'hA1B2C3D4);
            check("t1_ready0_mid", REQ0_READY, 0);
            tick();
        end
        check("t1_end_enb", CONV_ENB, 0);
        check("t1_end_busy", BUSY, 0);
        check("t1_end_bit", CONV_BIT, 0);
        check("t1_end_data", CONV_IN_DATA, 32'hA1B2C3D4);

        // width code 01 from requester 1
        REQ1_VALID = 1'b1; REQ1_DATA = 32'h0000BEEF; REQ1_PCLK = 2'b01;
        #1;
        check("t2_ready1", REQ1_READY, 1);
        check("t2_ready0", REQ0_READY, 0);
        tick();
        REQ1_VALID = 1'b0;
        check("t2_grant", GRANT, 1);
        check("t2_pclk", CONV_PCLK, 2'b01);
        check("t2_b0_enb", CONV_ENB, 1);
        check("t2_b0_bit", CONV_BIT, 0);
        tick();
        check("t2_b1_enb", CONV_ENB, 1);
        check("t2_b1_bit", CONV_BIT, 1);
        tick();
        check("t2_end_enb", CONV_ENB, 0);

        // width code 10: one byte
        REQ1_VALID = 1'b1; REQ1_DATA = 32'h00000055; REQ1_PCLK = 2'b10;
        tick();
        REQ1_VALID = 1'b0;
        check("t2_w1_enb", CONV_ENB, 1);
        check("t2_w1_bit", CONV_BIT, 0);
        check("t2_w1_data", CONV_IN_DATA, 32'h55);
        tick();
        check("t2_w1_end_enb", CONV_ENB, 0);

        // reserved width code 11
        REQ1_VALID = 1'b1; REQ1_DATA = 32'h12345678; REQ1_PCLK = 2'b11;
        tick();
        REQ1_VALID = 1'b0;
        check("t2_err_pulse", ERR, 1);
        check("t2_err_enb", CONV_ENB, 0);
        check("t2_err_busy", BUSY, 0);
        tick();
        check("t2_err_clear", ERR, 0);
        check("t2_err_enb2", CONV_ENB, 0);

        // async reset in the middle of a word owned by requester 1
        REQ1_VALID = 1'b1; REQ1_DATA = 32'hCAFEF00D; REQ1_PCLK = 2'b00;
        tick();
        REQ1_VALID = 1'b0;
        tick(); tick();
        check("t5_pre_bit", CONV_BIT, 2);
        check("t5_pre_grant", GRANT, 1);
        #2;
        RESET_L = 1'b0;
        #1;
        check("t5_enb", CONV_ENB, 0);
        check("t5_busy", BUSY, 0);
        check("t5_bit", CONV_BIT, 0);
        check("t5_grant", GRANT, 0);
        #2;
        RESET_L = 1'b1;
        REQ0_VALID = 1'b1; REQ0_DATA = 32'h0000009A; REQ0_PCLK = 2'b10;
        tick();
        REQ0_VALID = 1'b0;
        check("t5_new_enb", CONV_ENB, 1);
        check("t5_new_bit", CONV_BIT, 0);
        check("t5_new_data", CONV_IN_DATA, 32'h9A);
        tick();
        check("t5_no_resume", CONV_ENB, 0);

        // back-to-back 1-byte words, both requesters always valid
        REQ0_VALID = 1'b1; REQ0_DATA = 32'h10; REQ0_PCLK = 2'b10;
        REQ1_VALID = 1'b1; REQ1_DATA = 32'h20; REQ1_PCLK = 2'b10;
        #1;
        for (int i = 0; i < 9; i++) begin
            logic e;
            e = ((i / 4) % 2) == 1;
            check("t3_ready0", REQ0_READY, !e);
            check("t3_ready1", REQ1_READY, e);
            tick();
            check("t3_grant", GRANT, e);
            check("t3_enb", CONV_ENB, 1);
            check("t3_data", CONV_IN_DATA, e ? 32'h20 : 32'h10);
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        tick();
        check("t3_end_enb", CONV_ENB, 0);

        // sticky owner: requester 1 waits out four 4-byte words of requester 0
        REQ0_VALID = 1'b1; REQ0_DATA = 32'h01020304; REQ0_PCLK = 2'b00;
        tick();
        REQ1_VALID = 1'b1; REQ1_DATA = 32'h000000EE; REQ1_PCLK = 2'b10;
        #1;
        for (int w = 1; w <= 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                check("t4_bit", CONV_BIT, b);
                check("t4_grant", GRANT, 0);
                check("t4_ready0", REQ0_READY, (w < 4) && (b == 3));
                check("t4_ready1", REQ1_READY, (w == 4) && (b == 3));
                tick();
            end
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        check("t4_switch_grant", GRANT, 1);
        check("t4_switch_bit", CONV_BIT, 0);
        check("t4_switch_data", CONV_IN_DATA, 32'hEE);
        check("t4_switch_enb", CONV_ENB, 1);
        tick();
        check("t4_end_enb", CONV_ENB, 0);

        // idle gap between two requester 0 words, then contention
        REQ0_VALID = 1'b1; REQ0_DATA = 32'h0000AAAA; REQ0_PCLK = 2'b01;
        tick();
        REQ0_VALID = 1'b0;
        check("t6_w1_grant", GRANT, 0);
        tick(); tick();
        for (int g = 0; g < 3; g++) begin
            check("t6_gap_enb", CONV_ENB, 0);
            tick();
        end
        REQ0_VALID = 1'b1; REQ0_DATA = 32'h0000BBBB; REQ0_PCLK = 2'b01;
        #1;
        check("t6_ready0", REQ0_READY, 1);
        tick();
        check("t6_w2_enb", CONV_ENB, 1);
        check("t6_w2_bit", CONV_BIT, 0);
        check("t6_w2_data", CONV_IN_DATA, 32'hBBBB);
        REQ0_DATA = 32'h0000000C; REQ0_PCLK = 2'b10;
        REQ1_VALID = 1'b1; REQ1_DATA = 32'h0000000D; REQ1_PCLK = 2'b10;
        tick();
        check("t6_w2_b1", CONV_BIT, 1);
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (i == 3);
            check("t6_ready1", REQ1_READY, e);
            tick();
            check("t6_grant", GRANT, e);
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        tick();
        check("t6_end_enb", CONV_ENB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
